ftc_sync_debounce_edge: RTL
===========================

// Module: ftc_sync_debounce_edge
// PURPOSE
//  Consumes the output of a double-rank synchronizer (already in clk domain).
//  Qualifies the level with a stability filter, then emits a clean level plus
//  single-cycle rise and fall pulses. Counts rejected glitches for debug/CSR.
//  Sits directly downstream of each async-input synchronizer in the FTC block.
// PARAMETERS
//  STABLE_CYCLES  4     consecutive equal samples needed to accept a change (>=1)
//  CNT_W          8     width of the saturating glitch counter (>=1)
//  RSTVAL         1'b0  reset value of filt_level; must match the synchronizer RSTVAL
// PORTS
//  clk              in   1      block clock
//  rst_n            in   1      async active-low reset
//  test_mode_async  in   1      1 = bypass the filter (scan/test)
//  sync_in          in   1      synchronized level from the upstream synchronizer
//  clr_glitch_cnt   in   1      sync clear of glitch_cnt and glitch_cnt_sat
//  filt_level       out  1      debounced level
//  rise_pulse       out  1      1-cycle pulse when filt_level goes 0->1
//  fall_pulse       out  1      1-cycle pulse when filt_level goes 1->0
//  glitch_cnt       out  CNT_W  rejected-transition count, saturating
//  glitch_cnt_sat   out  1      sticky: glitch_cnt reached all-ones
// BEHAVIOUR
//  Clocking: single clock, asynchronous active-low reset. All outputs are registered.
//  Reset values:
//   - filt_level = RSTVAL; rise/fall = 0; glitch_cnt = 0; glitch_cnt_sat = 0.
//   - FSM = STABLE_HI if RSTVAL, else STABLE_LO; qual_cnt = 0.
//  FSM (qual_cnt width = $clog2(STABLE_CYCLES+1)):
//   STABLE_LO: sync_in=1 -> QUAL_HI, qual_cnt=1. Else stay.
//   QUAL_HI:   sync_in=1 & qual_cnt==STABLE_CYCLES-1 -> STABLE_HI, filt_level<=1,
//              rise_pulse<=1. sync_in=1 otherwise -> qual_cnt++.
//              sync_in=0 -> STABLE_LO, qual_cnt=0, glitch_cnt++.
//   STABLE_HI / QUAL_LO: mirror image (fall_pulse, filt_level<=0).
//  Latency:
//   - sync_in must be sampled high on STABLE_CYCLES consecutive edges.
//   - filt_level/rise_pulse update on the edge of the STABLE_CYCLES-th sample.
//   - STABLE_CYCLES=1: QUAL states unused; filt_level follows sync_in 1 cycle later.
//  Pulses:
//   - Exactly one cycle high per accepted transition; never both high at once.
//   - Pulses are high only in the cycle following an accepted change.
//  Glitch counter:
//   - Increments only on an aborted QUAL_* state.
//   - At all-ones it holds and sets glitch_cnt_sat, which stays set until clr.
//   - clr_glitch_cnt wins over a same-cycle increment (result 0, sat 0).
//  Test mode (test_mode_async=1):
//   - filt_level <= sync_in every cycle; rise/fall still pulse on any change.
//   - FSM forced to STABLE_* matching sync_in; qual_cnt=0; glitch_cnt frozen
//     (clr still honoured).
//   - Deassert: resume from that STABLE_* state, no spurious pulse.
//  Reset mid-qualification: all state returns to reset values immediately;
//   no pulse is emitted on or after reset release unless a new change qualifies.
// TESTING
//  1 Reset RSTVAL=0, sync_in=0 -> filt_level=0, pulses 0, glitch_cnt=0.
//  2 STABLE_CYCLES=4, sync_in 0->1 held -> rise_pulse on 4th high edge, one cycle;
//    filt_level=1 from then. Same for 1->0 with fall_pulse.
//  3 sync_in high for 3 cycles then low -> no pulse, filt_level=0, glitch_cnt=1.
//  4 CNT_W=2, 5 glitches -> glitch_cnt=3, sat=1. clr together with a glitch -> 0/0.
//  5 test_mode=1, toggle sync_in every cycle -> filt_level tracks with 1 cycle delay,
//    alternating pulses, glitch_cnt unchanged.
//  6 rst_n low in QUAL_HI (qual_cnt=2), release with sync_in=1 -> rise only after
//    4 new high samples.

Source files
------------

// File: rtl/ftc_sync_debounce_edge.sv
// ---------------------------------------------------------------------------
// ftc_sync_debounce_edge
//
// Sits directly behind an async-input double-rank synchronizer. It accepts a
// level change only after STABLE_CYCLES consecutive equal samples. It then
// emits the clean level plus single-cycle rise/fall pulses. Aborted
// qualifications are counted in a saturating glitch counter for debug/CSR
// readback.
//
// Parameters
//   STABLE_CYCLES  consecutive equal samples needed to accept a change (>=1)
//   CNT_W          width of the saturating glitch counter (>=1)
//   RSTVAL         reset value of filt_level (match the upstream synchronizer)
//
// Ports
//   clk             in   1      block clock
//   rst_n           in   1      async active-low reset
//   test_mode_async in   1      1 = bypass the filter (scan/test)
//   sync_in         in   1      synchronized level (already in clk domain)
//   clr_glitch_cnt  in   1      sync clear of glitch_cnt and glitch_cnt_sat
//   filt_level      out  1      debounced level
//   rise_pulse      out  1      1-cycle pulse on accepted 0->1
//   fall_pulse      out  1      1-cycle pulse on accepted 1->0
//   glitch_cnt      out  CNT_W  rejected-transition count, saturating
//   glitch_cnt_sat  out  1      sticky, set once glitch_cnt reaches all-ones
// ---------------------------------------------------------------------------
module ftc_sync_debounce_edge #(
  parameter int   STABLE_CYCLES = 4,
  parameter int   CNT_W         = 8,
  parameter logic RSTVAL        = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_mode_async,
  input  logic             sync_in,
  input  logic             clr_glitch_cnt,
  output logic             filt_level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             glitch_cnt_sat
);

  localparam int QW = $clog2(STABLE_CYCLES + 1);
  localparam logic [QW-1:0]    QUAL_LAST = QW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_QUAL_HI   = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_QUAL_LO   = 2'd3;
  localparam logic [1:0] ST_RESET     = RSTVAL ? ST_STABLE_HI : ST_STABLE_LO;

  logic [1:0]       r_state;
  logic [QW-1:0]    r_qual_cnt;
  logic             r_filt_level;
  logic             r_rise_pulse;
  logic             r_fall_pulse;
  logic [CNT_W-1:0] r_glitch_cnt;
  logic             r_glitch_cnt_sat;

  logic [1:0]       w_state_nxt;
  logic [QW-1:0]    w_qual_nxt;
  logic             w_level_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_glitch_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sat_nxt;

  // Qualification FSM. The STABLE_* states always agree with r_filt_level;
  // the QUAL_* states count samples that disagree with it.
  always_comb begin
    // NOTE: every combinational output is defaulted first, so no path leaves
    // a variable unassigned and no latch is inferred.
    w_state_nxt  = r_state;
    w_qual_nxt   = r_qual_cnt;
    w_level_nxt  = r_filt_level;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    w_glitch_inc = 1'b0;

    if (test_mode_async) begin
      // Bypass: follow sync_in directly. Parking the FSM in the matching
      // stable state makes test-mode exit glitch-free.
      w_level_nxt = sync_in;
      w_rise_nxt  = sync_in & ~r_filt_level;
      w_fall_nxt  = ~sync_in & r_filt_level;
      w_state_nxt = sync_in ? ST_STABLE_HI : ST_STABLE_LO;
      w_qual_nxt  = '0;
    end else begin
      case (r_state)
        ST_STABLE_LO: begin
          if (sync_in) begin
            if (STABLE_CYCLES == 1) begin
              w_state_nxt = ST_STABLE_HI;
              w_level_nxt = 1'b1;
              w_rise_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_QUAL_HI;
              w_qual_nxt  = QW'(1);
            end
          end
        end
        ST_QUAL_HI: begin
          if (!sync_in) begin
            w_state_nxt  = ST_STABLE_LO;
            w_qual_nxt   = '0;
            w_glitch_inc = 1'b1;
          end else if (r_qual_cnt == QUAL_LAST) begin
            w_state_nxt = ST_STABLE_HI;
            w_qual_nxt  = '0;
            w_level_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_qual_nxt = r_qual_cnt + QW'(1);
          end
        end
        ST_STABLE_HI: begin
          if (!sync_in) begin
            if (STABLE_CYCLES == 1) begin
              w_state_nxt = ST_STABLE_LO;
              w_level_nxt = 1'b0;
              w_fall_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_QUAL_LO;
              w_qual_nxt  = QW'(1);
            end
          end
        end
        ST_QUAL_LO: begin
          if (sync_in) begin
            w_state_nxt  = ST_STABLE_HI;
            w_qual_nxt   = '0;
            w_glitch_inc = 1'b1;
          end else if (r_qual_cnt == QUAL_LAST) begin
            w_state_nxt = ST_STABLE_LO;
            w_qual_nxt  = '0;
            w_level_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_qual_nxt = r_qual_cnt + QW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_RESET;
          w_qual_nxt  = '0;
        end
      endcase
    end
  end

  // Saturating glitch counter. A clear beats a same-cycle increment, and the
  // sticky flag rises together with the counter reaching all-ones.
  always_comb begin
    w_cnt_nxt = r_glitch_cnt;
    w_sat_nxt = r_glitch_cnt_sat;
    if (clr_glitch_cnt) begin
      w_cnt_nxt = '0;
      w_sat_nxt = 1'b0;
    end else if (w_glitch_inc) begin
      if (r_glitch_cnt != CNT_MAX) begin
        w_cnt_nxt = r_glitch_cnt + CNT_W'(1);
      end
      if (w_cnt_nxt == CNT_MAX) begin
        w_sat_nxt = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_RESET;
      r_qual_cnt       <= '0;
      r_filt_level     <= RSTVAL;
      r_rise_pulse     <= 1'b0;
      r_fall_pulse     <= 1'b0;
      r_glitch_cnt     <= '0;
      r_glitch_cnt_sat <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_qual_cnt       <= w_qual_nxt;
      r_filt_level     <= w_level_nxt;
      r_rise_pulse     <= w_rise_nxt;
      r_fall_pulse     <= w_fall_nxt;
      r_glitch_cnt     <= w_cnt_nxt;
      r_glitch_cnt_sat <= w_sat_nxt;
    end
  end

  assign filt_level     = r_filt_level;
  assign rise_pulse     = r_rise_pulse;
  assign fall_pulse     = r_fall_pulse;
  assign glitch_cnt     = r_glitch_cnt;
  assign glitch_cnt_sat = r_glitch_cnt_sat;

endmodule
